// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider: square-wave or single-cycle tick output,
// with new divisors taken over a valid/ready port and applied only at a period boundary.
module prog_clk_div #(
    parameter int unsigned CNT_W       = 29,
    parameter int unsigned DEFAULT_DIV = 100000000
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             En,
    input  logic             Mode,
    input  logic [CNT_W-1:0] DivIn,
    input  logic             DivLoad,
    output logic             DivReady,
    output logic             ClkOut,
    output logic             Tick,
    output logic [CNT_W-1:0] CurDiv
);

    logic [CNT_W-1:0] Cnt;
    logic [CNT_W-1:0] DivSel;
    logic [CNT_W-1:0] Pend;
    logic             PendV;
    logic             ModeQ;

    logic terminal;
    logic loadAccept;
    logic restart;
    logic applyEdge;

    assign DivReady   = ~PendV;
    assign CurDiv     = DivSel;
    assign terminal   = (Cnt == DivSel);
    assign loadAccept = DivLoad & ~PendV;
    assign restart    = (Mode != ModeQ);
    // Square mode swaps only on the falling terminal edge so a full period always completes.
    assign applyEdge  = terminal & PendV & (ModeQ | ClkOut);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Cnt    <= '0;
            DivSel <= CNT_W'(DEFAULT_DIV);
            Pend   <= '0;
            PendV  <= 1'b0;
            ModeQ  <= 1'b0;
            ClkOut <= 1'b0;
            Tick   <= 1'b0;
        end else begin
            ModeQ <= Mode;

            // Accepting only while PendV is low keeps this disjoint from the apply paths below.
            if (loadAccept) begin
                Pend  <= DivIn;
                PendV <= 1'b1;
            end

            if (!En) begin
                Cnt    <= '0;
                ClkOut <= 1'b0;
                Tick   <= 1'b0;
                if (PendV) begin
                    DivSel <= Pend;
                    PendV  <= 1'b0;
                end
            end else if (restart) begin
                Cnt    <= '0;
                ClkOut <= 1'b0;
                Tick   <= 1'b0;
            end else if (terminal) begin
                Cnt <= '0;
                if (ModeQ) begin
                    ClkOut <= 1'b0;
                    Tick   <= 1'b1;
                end else begin
                    ClkOut <= ~ClkOut;
                    Tick   <= ~ClkOut;
                end
                if (applyEdge) begin
                    DivSel <= Pend;
                    PendV  <= 1'b0;
                end
            end else begin
                Cnt  <= Cnt + CNT_W'(1);
                Tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_clk_div.sv
// Scoreboard bench for prog_clk_div: the driver queues hand-computed post-edge outputs,
// a monitor pops and compares them at each falling clock edge or on an explicit sample event.
module tb_prog_clk_div;

    logic       Clk;
    logic       Rst_n;
    logic       En;
    logic       Mode;
    logic [7:0] DivIn;
    logic       DivLoad;
    logic       DivReady;
    logic       ClkOut;
    logic       Tick;
    logic [7:0] CurDiv;

    typedef struct {
        logic       clk;
        logic       tick;
        logic       rdy;
        logic [7:0] cur;
        string      tag;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   driverDone = 0;
    event sampleEv;

    prog_clk_div #(
        .CNT_W      (8),
        .DEFAULT_DIV(3)
    ) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .En      (En),
        .Mode    (Mode),
        .DivIn   (DivIn),
        .DivLoad (DivLoad),
        .DivReady(DivReady),
        .ClkOut  (ClkOut),
        .Tick    (Tick),
        .CurDiv  (CurDiv)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic pushExp(input logic eClk, input logic eTick, input logic eRdy,
                           input logic [7:0] eCur, input string tag);
        exp_t e;
        e.clk  = eClk;
        e.tick = eTick;
        e.rdy  = eRdy;
        e.cur  = eCur;
        e.tag  = tag;
        expQ.push_back(e);
    endtask

    // Drive one edge worth of inputs, then queue the outputs expected after that edge.
    task automatic step(input logic rstN, input logic en, input logic mode, input logic load,
                        input logic [7:0] din, input logic eClk, input logic eTick,
                        input logic eRdy, input logic [7:0] eCur, input string tag);
        Rst_n   = rstN;
        En      = en;
        Mode    = mode;
        DivLoad = load;
        DivIn   = din;
        @(posedge Clk);
        #1;
        pushExp(eClk, eTick, eRdy, eCur, tag);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk or sampleEv);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                compared++;
                if ({ClkOut, Tick, DivReady, CurDiv} !== {e.clk, e.tick, e.rdy, e.cur}) begin
                    mismatched++;
                    $display("FAIL %s: got ClkOut=%b Tick=%b DivReady=%b CurDiv=%0d, want ClkOut=%b Tick=%b DivReady=%b CurDiv=%0d",
                             e.tag, ClkOut, Tick, DivReady, CurDiv, e.clk, e.tick, e.rdy, e.cur);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "watchdog expired");
    end

    // Driver
    initial begin
        Rst_n   = 1'b0;
        En      = 1'b1;
        Mode    = 1'b0;
        DivLoad = 1'b0;
        DivIn   = '0;

        step(0, 1, 0, 0, 0, 0, 0, 1, 3, "reset0");
        step(0, 1, 0, 0, 0, 0, 0, 1, 3, "reset1");

        // Default divisor 3: half-period of 4 edges, tick on each rising edge.
        for (int e = 1; e <= 20; e++) begin
            logic c;
            c = ((e / 4) % 2) == 1;
            step(1, 1, 0, 0, 0, c, c && (e % 4 == 0), 1, 3, $sformatf("default_e%0d", e));
        end

        // Load 1 mid high phase; applied at the falling edge ending the period.
        step(1, 1, 0, 1, 1, 1, 0, 0, 3, "bload_e21");
        step(1, 1, 0, 0, 0, 1, 0, 0, 3, "bload_e22");
        step(1, 1, 0, 0, 0, 1, 0, 0, 3, "bload_e23");
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, "bload_apply");
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, "bload_e25");
        step(1, 1, 0, 0, 0, 1, 1, 1, 1, "bload_rise");
        step(1, 1, 0, 0, 0, 1, 0, 1, 1, "bload_e27");
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, "bload_fall");
        step(1, 1, 0, 0, 0, 0, 0, 1, 1, "bload_e29");
        step(1, 1, 0, 0, 0, 1, 1, 1, 1, "bload_rise2");

        // Disable mid high phase while loading 4; idle applies it next edge.
        step(1, 0, 0, 1, 4, 0, 0, 0, 1, "dis_high");
        step(1, 0, 0, 0, 0, 0, 0, 1, 4, "dis_apply");

        // Pulse mode at divisor 4 (first edge is a mode restart).
        step(1, 1, 1, 0, 0, 0, 0, 1, 4, "pulse_restart");
        for (int k = 1; k <= 10; k++)
            step(1, 1, 1, 0, 0, 0, (k % 5) == 0, 1, 4, $sformatf("pulse_k%0d", k));
        step(1, 1, 1, 1, 0, 0, 0, 0, 4, "pulse_load0");
        for (int k = 1; k <= 3; k++)
            step(1, 1, 1, 0, 0, 0, 0, 0, 4, $sformatf("pulse_wait%0d", k));
        step(1, 1, 1, 0, 0, 0, 1, 1, 0, "pulse_apply0");
        for (int k = 1; k <= 3; k++)
            step(1, 1, 1, 0, 0, 0, 1, 1, 0, $sformatf("pulse_div0_%0d", k));

        // Idle apply of 6, then square mode from enable.
        step(1, 0, 1, 1, 6, 0, 0, 0, 0, "idle_load");
        step(1, 0, 0, 0, 0, 0, 0, 1, 6, "idle_apply");
        for (int k = 1; k <= 7; k++)
            step(1, 1, 0, 0, 0, k == 7, k == 7, 1, 6, $sformatf("idle_run%0d", k));
        step(1, 1, 0, 0, 0, 1, 0, 1, 6, "idle_high");

        // Mode toggle while high restarts the count from zero.
        step(1, 1, 1, 0, 0, 0, 0, 1, 6, "mode_restart");
        for (int k = 1; k <= 7; k++)
            step(1, 1, 1, 0, 0, 0, k == 7, 1, 6, $sformatf("mode_cnt%0d", k));

        // Pending load then asynchronous reset between edges.
        step(1, 1, 1, 1, 9, 0, 0, 0, 6, "arst_pend");
        @(negedge Clk);
        #2;
        Rst_n   = 1'b0;
        DivLoad = 1'b0;
        #1;
        pushExp(0, 0, 1, 3, "arst_async");
        ->sampleEv;
        step(0, 1, 0, 0, 0, 0, 0, 1, 3, "arst_hold");
        for (int k = 1; k <= 8; k++)
            step(1, 1, 0, 0, 0, (k >= 4) && (k < 8), k == 4, 1, 3, $sformatf("arst_run%0d", k));

        @(negedge Clk);
        #1;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d unchecked entries, want 0", expQ.size());
        end
        driverDone = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prog_clk_div.md
# prog_clk_div

Runtime-programmable clock divider for the game/display timing path, replacing fixed divisor look-up tables. It divides `Clk` by any value loaded over a valid/ready port. It produces either a square-wave `ClkOut` or a single-cycle `Tick` enable. New divisors are applied only at a period boundary, so no output phase is ever truncated.

## Interface
- `CNT_W`, 29, width of the divisor and internal counter.
- `DEFAULT_DIV`, 100000000, divisor loaded at reset (0.5 Hz square from 100 MHz).
- `Clk  in  1`  system clock (100 MHz).
- `Rst_n  in  1`  reset; one clock, asynchronous, active-low.
- `En  in  1`  run enable; low holds the divider idle.
- `Mode  in  1`  0 = square output on `ClkOut`; 1 = pulse output on `Tick` only.
- `DivIn  in  CNT_W`  divisor value offered for load.
- `DivLoad  in  1`  valid for `DivIn`.
- `DivReady  out  1`  ready; a load is accepted on an edge where `DivLoad` and `DivReady` are both 1.
- `ClkOut  out  1`  registered divided clock (square mode); 0 in pulse mode.
- `Tick  out  1`  registered one-cycle pulse per output period.
- `CurDiv  out  CNT_W`  divisor currently in effect.

## Operation
- Registers: `Cnt[CNT_W]`, `DivSel[CNT_W]` (drives `CurDiv`), `Pend[CNT_W]`, `PendV`, `ModeQ`, `ClkOut`, `Tick`.
- Counting rule (`En`=1, no restart): if `Cnt==DivSel`, then `Cnt<=0` and it is a terminal edge; otherwise `Cnt<=Cnt+1`. One half-period (square) or one period (pulse) is `DivSel+1` clocks.
- Square mode: on a terminal edge `ClkOut` toggles. The output period is `2*(DivSel+1)`. `Tick`=1 for exactly the cycle following a terminal edge on which `ClkOut` went 0->1.
- Pulse mode: `ClkOut` is held 0. `Tick`=1 for the cycle following every terminal edge.
- `DivSel`=0 is legal: Clk/2 in square mode, `Tick` continuously high in pulse mode.
- Load: an accepted load sets `Pend<=DivIn` and `PendV<=1`. `DivReady = ~PendV`.
- Apply boundary:
  - Square mode: a terminal edge with `ClkOut`=1, i.e. the falling edge ending a full period.
  - Pulse mode: any terminal edge.
  - At the boundary, `DivSel<=Pend`, `PendV<=0`, and `Cnt<=0`.
- `PendV` is evaluated with its pre-edge value. A load accepted on a boundary edge waits for the next boundary.
- `En`=0:
  - `Cnt<=0`, `ClkOut<=0`, `Tick<=0`.
  - If `PendV`, the pending value is applied immediately: `DivSel<=Pend`, `PendV<=0`.
- Mode change: `ModeQ` registers `Mode`. When `Mode != ModeQ` with `En`=1, the divider restarts: `Cnt<=0`, `ClkOut<=0`, `Tick<=0`. The pending load is kept.
- No divisor value is rejected. The counter never exceeds `DivSel`.

## Timing
- Reset values (asynchronous): `Cnt`=0, `DivSel`=`CurDiv`=`DEFAULT_DIV`, `Pend`=0, `PendV`=0, `DivReady`=1, `ClkOut`=0, `Tick`=0, `ModeQ`=0.
- On `Rst_n` deassertion, the first counting edge is the first `Clk` rising edge with `Rst_n`=1 and `En`=1.
- From `En` first sampled high, with divisor D:
  - Square mode: `ClkOut` rises after edge D+1 and falls after edge 2(D+1). The `Tick` cycle coincides with the first `ClkOut`-high cycle.
  - Pulse mode: `Tick` is high after edges D+1, 2(D+1), and so on.
- `DivReady` is low from the cycle after acceptance until the cycle after the apply edge.
- `CurDiv` changes in the same cycle as the restart of `Cnt`.
- `En` falling forces `ClkOut` low on the next edge and may truncate a high phase. This is the only truncation allowed.
- Reset asserted mid-period: all registers return to reset values immediately, and any pending load is discarded.

## Test plan
- Reset default: hold `Rst_n`=0, then release with `En`=1, `Mode`=0, `CNT_W`=8, `DEFAULT_DIV`=3 -> `ClkOut` rises after edge 4 and has period 8; `Tick` is high 1 cycle of every 8; `DivReady`=1.
- Boundary load: with D=3, load `DivIn`=1 mid high phase -> `DivReady` drops; the current period completes with 4 high cycles; the next period is 4 cycles (2 high, 2 low); `CurDiv`=1; `DivReady` returns the cycle after apply.
- Pulse mode: `Mode`=1, D=4 -> `ClkOut`=0 and `Tick` is high every 5th cycle. Loading 0 gives `Tick` continuously high after the next terminal edge.
- Idle apply: `En`=0, load `DivIn`=6 -> `CurDiv`=6 one cycle later, `DivReady` high again. With `En`=1, `ClkOut` rises after edge 7.
- Mode restart and disable: toggle `Mode` while `ClkOut`=1 -> `ClkOut`=0 and `Cnt`=0 next cycle. Drop `En` mid high -> `ClkOut`=0 next edge, no `Tick`.
- Async reset mid-operation, with a pending load: assert `Rst_n`=0 between edges -> outputs reach reset values without waiting for a clock; `CurDiv`=`DEFAULT_DIV`; the pending load is lost.
